// File: rtl/switch_input_conditioner_pkg.sv
// Shared types and constants for the switch input front end.
package switch_input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VALID   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int SW_W                = 10;
  localparam int SW_ENTER_BIT        = 8;
  localparam int SW_RUN_BIT          = 9;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/switch_input_conditioner_if.sv
// Data handshake between the switch conditioner (master) and the CPU (slave).
interface switch_input_conditioner_if #(
  parameter int N = 8
);
  logic [N-1:0] dataOut;
  logic         dataValid;
  logic         dataAck;

  modport master (output dataOut, output dataValid, input dataAck);
  modport slave  (input dataOut, input dataValid, output dataAck);
endinterface

// File: rtl/switch_input_conditioner_sync_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer: deb only takes
// a new value after the synchronised vector has been unchanged for
// DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int W               = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [W-1:0] din,
  output logic [W-1:0] deb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     s1;
  logic [W-1:0]     s2;
  logic [W-1:0]     s3;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switches into the clk domain.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Stability window: any bit change restarts it; the count saturates, and
  // the increment that lands on the terminal count publishes the vector.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s3  <= '0;
      cnt <= '0;
      deb <= '0;
    end else begin
      s3 <= s2;
      if (s2 != s3) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          deb <= s2;
        end
      end
    end
  end

endmodule

// File: rtl/switch_input_conditioner.sv
// Switch front end: debounces SW, exposes SW[9] as run enable and turns each
// press of SW[8] into exactly one valid/ack transfer of SW[N-1:0].
//
// state   | meaning
// IDLE    | waiting for debounced enter
// VALID   | byte captured and frozen, dataValid high until dataAck
// RELEASE | byte consumed, waiting for enter to be released
module switch_input_conditioner
  import switch_input_conditioner_pkg::*;
#(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         nRst,
  input  logic [SW_W-1:0]              SW,
  switch_input_conditioner_if.master   hs,
  output logic                         runEnable,
  output logic [SW_W-1:0]              debSw
);

  logic [SW_W-1:0] deb;
  state_t          state;
  state_t          state_next;
  logic            load;
  logic [N-1:0]    data_q;
  logic            valid_q;

  sync_debounce #(
    .W              (SW_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sync_debounce (
    .clk (clk),
    .nRst(nRst),
    .din (SW),
    .deb (deb)
  );

  // Next-state and capture decision; ack only matters in VALID.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (deb[SW_ENTER_BIT]) begin
          state_next = VALID;
          load       = 1'b1;
        end
      end
      VALID: begin
        if (hs.dataAck) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!deb[SW_ENTER_BIT]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Captured byte and valid flag; the byte only loads on the IDLE->VALID step.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= deb[N-1:0];
      end
      valid_q <= (state_next == VALID);
    end
  end

  assign hs.dataOut   = data_q;
  assign hs.dataValid = valid_q;
  assign debSw        = deb;
  assign runEnable    = deb[SW_RUN_BIT];

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Self-checking bench for switch_input_conditioner with a 4-cycle debounce.
module tb_switch_input_conditioner;

  localparam int N   = 8;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       nRst;
  logic [9:0] SW;
  logic       runEnable;
  logic [9:0] debSw;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  typedef struct {
    logic       run;
    logic [7:0] data;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[4];

  switch_input_conditioner_if #(.N(N)) hs_if ();

  switch_input_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .SW       (SW),
    .hs       (hs_if.master),
    .runEnable(runEnable),
    .debSw    (debSw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each rising dataValid must match the oldest expected capture.
  always @(posedge clk) begin
    #1;
    if (hs_if.dataValid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_capture actual=0x%0h required=none", hs_if.dataOut);
      end else begin
        check("capture_data", {24'd0, hs_if.dataOut}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = hs_if.dataValid;
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (hs_if.dataValid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_pulse(input string name);
    hs_if.dataAck = 1'b1;
    tick();
    check(name, {31'd0, hs_if.dataValid}, 32'd0);
    hs_if.dataAck = 1'b0;
  endtask

  initial begin
    int  lat;
    logic seen;

    vecs[0] = '{run: 1'b0, data: 8'hA5, exp_data: 8'hA5, exp_lat: DEB + 4};
    vecs[1] = '{run: 1'b1, data: 8'h00, exp_data: 8'h00, exp_lat: DEB + 4};
    vecs[2] = '{run: 1'b1, data: 8'h5A, exp_data: 8'h5A, exp_lat: DEB + 4};
    vecs[3] = '{run: 1'b0, data: 8'hFF, exp_data: 8'hFF, exp_lat: DEB + 4};

    // Reset with all switches on.
    nRst          = 1'b0;
    SW            = 10'h3FF;
    hs_if.dataAck = 1'b0;
    repeat (4) tick();
    check("rst_valid", {31'd0, hs_if.dataValid}, 32'd0);
    check("rst_data", {24'd0, hs_if.dataOut}, 32'd0);
    check("rst_debsw", {22'd0, debSw}, 32'd0);
    check("rst_run", {31'd0, runEnable}, 32'd0);
    exp_q.push_back(8'hFF);
    nRst = 1'b1;
    repeat (6) tick();
    check("rst_debsw_edge6", {22'd0, debSw}, 32'd0);
    tick();
    check("rst_debsw_edge7", {22'd0, debSw}, 32'h3FF);
    check("rst_run_edge7", {31'd0, runEnable}, 32'd1);
    check("rst_valid_edge7", {31'd0, hs_if.dataValid}, 32'd0);
    tick();
    check("rst_valid_edge8", {31'd0, hs_if.dataValid}, 32'd1);
    ack_pulse("rst_ack_drop");
    SW = 10'h000;
    repeat (DEB + 4) tick();

    // Table-driven clean captures.
    for (int v = 0; v < 4; v++) begin
      SW = {vecs[v].run, 1'b0, vecs[v].data};
      repeat (DEB + 4) tick();
      SW = {vecs[v].run, 1'b1, vecs[v].data};
      exp_q.push_back(vecs[v].exp_data);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_run", v), {31'd0, runEnable}, {31'd0, vecs[v].run});
      repeat (3) tick();
      check($sformatf("vec%0d_hold", v), {31'd0, hs_if.dataValid}, 32'd1);
      ack_pulse($sformatf("vec%0d_ack_drop", v));
      SW = {vecs[v].run, 1'b0, vecs[v].data};
      repeat (DEB + 4) tick();
    end

    // Bounce on enter: no debounced change until a full stable window.
    SW   = 10'h05A;
    repeat (DEB + 4) tick();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      SW[8] = ~SW[8];
      tick();
      seen |= debSw[8];
      tick();
      seen |= debSw[8];
    end
    SW[8] = 1'b1;
    exp_q.push_back(8'h5A);
    repeat (DEB + 2) begin
      tick();
      seen |= debSw[8];
    end
    check("bounce_no_early_enter", {31'd0, seen}, 32'd0);
    tick();
    check("bounce_enter_edge7", {31'd0, debSw[8]}, 32'd1);
    tick();
    check("bounce_valid", {31'd0, hs_if.dataValid}, 32'd1);
    repeat (10) tick();
    ack_pulse("bounce_ack_drop");

    // Hold enter after ack and change data: no recapture until re-press.
    SW = 10'h13C;
    repeat (15) tick();
    check("hold_no_valid", {31'd0, hs_if.dataValid}, 32'd0);
    SW = 10'h03C;
    repeat (DEB + 4) tick();
    SW = 10'h13C;
    exp_q.push_back(8'h3C);
    wait_valid(lat);
    check("recapture_latency", lat, DEB + 4);
    ack_pulse("recapture_ack_drop");
    SW = 10'h03C;
    repeat (DEB + 4) tick();

    // Frozen data while VALID; enter released before ack.
    SW = 10'h011;
    repeat (DEB + 4) tick();
    SW = 10'h111;
    exp_q.push_back(8'h11);
    wait_valid(lat);
    SW = 10'h122;
    repeat (10) tick();
    check("frozen_data", {24'd0, hs_if.dataOut}, 32'h11);
    SW = 10'h022;
    repeat (10) tick();
    check("frozen_data_released", {24'd0, hs_if.dataOut}, 32'h11);
    check("frozen_still_valid", {31'd0, hs_if.dataValid}, 32'd1);
    ack_pulse("frozen_ack_drop");
    repeat (2) tick();
    hs_if.dataAck = 1'b1;
    repeat (3) tick();
    check("idle_ack_ignored", {31'd0, hs_if.dataValid}, 32'd0);
    hs_if.dataAck = 1'b0;
    SW = 10'h122;
    exp_q.push_back(8'h22);
    wait_valid(lat);
    check("after_idle_ack_latency", lat, DEB + 4);
    ack_pulse("after_idle_ack_drop");
    SW = 10'h022;
    repeat (DEB + 4) tick();

    // Asynchronous reset in the middle of VALID.
    SW = 10'h277;
    repeat (DEB + 4) tick();
    SW = 10'h377;
    exp_q.push_back(8'h77);
    wait_valid(lat);
    #2;
    nRst = 1'b0;
    #1;
    check("midrst_valid", {31'd0, hs_if.dataValid}, 32'd0);
    check("midrst_data", {24'd0, hs_if.dataOut}, 32'd0);
    check("midrst_run", {31'd0, runEnable}, 32'd0);
    repeat (2) tick();
    exp_q.push_back(8'h77);
    nRst = 1'b1;
    repeat (6) tick();
    check("midrst_run_edge6", {31'd0, runEnable}, 32'd0);
    tick();
    check("midrst_run_edge7", {31'd0, runEnable}, 32'd1);
    tick();
    check("midrst_valid_edge8", {31'd0, hs_if.dataValid}, 32'd1);
    ack_pulse("midrst_ack_drop");
    SW = 10'h000;
    repeat (DEB + 4) tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
